// File: rtl/regfile_pkg.sv
// Shared constants and FSM state type for the register-file port arbiter.
package regfile_pkg;

  localparam int RF_AW    = 6;
  localparam int RF_DW    = 32;
  localparam int RF_DEPTH = 64;

  typedef enum logic {
    CLEAR = 1'b0,
    ARB   = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or above ptr, wrapping.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [PW-1:0]   winner,
  output logic            anyGnt
);

  // Rotating priority scan; the first hit blocks all later candidates.
  always_comb begin
    int  idx;
    logic hit;
    gnt    = {NREQ{1'b0}};
    winner = {PW{1'b0}};
    anyGnt = 1'b0;
    idx    = 0;
    hit    = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx      = (int'(ptr) + k) % NREQ;
      hit      = !anyGnt && req[idx];
      gnt[idx] = gnt[idx] | hit;
      winner   = hit ? PW'(idx) : winner;
      anyGnt   = anyGnt | hit;
    end
  end

endmodule

// File: rtl/regfile_port_arbiter.sv
// Round-robin owner of the register file ports, with a 64-cycle hardware clear.
// Optional: define REGFILE_ARB_R0_ZERO_EN to make address 0 read as zero and ignore writes.
module regfile_port_arbiter
  import regfile_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int AW   = RF_AW,
  parameter int DW   = RF_DW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  req_we,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]  gnt,
  output logic [NREQ-1:0]  rvalid,
  output logic [DW-1:0]    rdata,
  output logic             busy,
  output logic [AW-1:0]    rf_raddr,
  output logic [AW-1:0]    rf_waddr,
  output logic [DW-1:0]    rf_wdin,
  output logic             rf_wena,
  input  logic [DW-1:0]    rf_rdout
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [AW-1:0] LAST_ADDR = {AW{1'b1}};
  localparam logic [PW-1:0] LAST_REQ  = PW'(NREQ - 1);

  arb_state_t      state;
  logic [AW-1:0]   clrCnt;
  logic [PW-1:0]   rrPtr;
  logic [NREQ-1:0] arbGnt;
  logic [PW-1:0]   winner;
  logic            anyGnt;
  logic            grantOn;
  logic            selWe;
  logic [AW-1:0]   selAddr;
  logic [DW-1:0]   selWdata;
  logic            addrZero;

  rr_arbiter #(.NREQ(NREQ), .PW(PW)) uArb (
    .req    (req),
    .ptr    (rrPtr),
    .gnt    (arbGnt),
    .winner (winner),
    .anyGnt (anyGnt)
  );

  // A grant is only real in ARB, outside reset, and not in a clear-request cycle.
  assign grantOn  = rst_n && (state == ARB) && !clr && anyGnt;
  assign gnt      = grantOn ? arbGnt : {NREQ{1'b0}};
  assign busy     = !rst_n || (state == CLEAR);
  assign selWe    = req_we[winner];
  assign selAddr  = req_addr[int'(winner)*AW +: AW];
  assign selWdata = req_wdata[int'(winner)*DW +: DW];

`ifdef REGFILE_ARB_R0_ZERO_EN
  assign addrZero = (selAddr == {AW{1'b0}});
`else
  assign addrZero = 1'b0;
`endif

  // Register-file pin drive: clear sweep, granted write or granted read.
  always_comb begin
    rf_wena  = 1'b0;
    rf_waddr = {AW{1'b0}};
    rf_raddr = {AW{1'b0}};
    rf_wdin  = {DW{1'b0}};
    case (state)
      CLEAR: begin
        rf_wena  = 1'b1;
        rf_waddr = clrCnt;
      end
      ARB: begin
        if (grantOn && selWe) begin
          rf_wena  = !addrZero;
          rf_waddr = selAddr;
          rf_wdin  = selWdata;
        end else if (grantOn) begin
          rf_raddr = selAddr;
        end else begin
          rf_wena  = 1'b0;
        end
      end
      default: begin
        rf_wena  = 1'b0;
      end
    endcase
  end

  // FSM, clear counter, round-robin pointer and read-response registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= CLEAR;
      clrCnt <= {AW{1'b0}};
      rrPtr  <= {PW{1'b0}};
      rvalid <= {NREQ{1'b0}};
      rdata  <= {DW{1'b0}};
    end else begin
      rvalid <= {NREQ{1'b0}};
      case (state)
        CLEAR: begin
          if (clr) begin
            clrCnt <= {AW{1'b0}};
          end else if (clrCnt == LAST_ADDR) begin
            clrCnt <= {AW{1'b0}};
            state  <= ARB;
          end else begin
            clrCnt <= clrCnt + AW'(1);
          end
        end
        ARB: begin
          if (clr) begin
            clrCnt <= {AW{1'b0}};
            state  <= CLEAR;
          end else if (grantOn) begin
            rrPtr <= (winner == LAST_REQ) ? {PW{1'b0}} : winner + PW'(1);
            if (!selWe) begin
              rvalid <= arbGnt;
              rdata  <= addrZero ? {DW{1'b0}} : rf_rdout;
            end
          end
        end
        default: begin
          state <= CLEAR;
        end
      endcase
    end
  end

endmodule

// File: doc/regfile_port_arbiter.md
Name: regfile_port_arbiter

Overview:
- Shares the single read port and single write port of the 64x32 register file among NREQ requesters using round-robin arbitration.
- After reset, or on a clear command, it sequences a hardware clear: one zero-write per cycle across all 64 entries.
- Sits between the control FSMs/datapath units and the register file, and is the only block that drives the register file address and enable pins.

Parameters:
- NREQ, 4, number of requesters (2..8).
- AW, 6, register address width (depth = 2**AW = 64).
- DW, 32, data width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset: synchronous, active-low.
- clr  in  1  one-cycle pulse; starts a clear sequence.
- req  in  NREQ  per-requester request; held until granted.
- req_we  in  NREQ  per-requester: 1 = write, 0 = read.
- req_addr  in  NREQ*AW  packed addresses; requester i uses bits [i*AW +: AW].
- req_wdata  in  NREQ*DW  packed write data.
- gnt  out  NREQ  one-hot, combinational; the transfer happens in the cycle where req[i] and gnt[i] are both 1.
- rvalid  out  NREQ  one-hot, registered; read data valid, 1-cycle pulse.
- rdata  out  DW  registered read data, shared by all requesters.
- busy  out  1  high while the clear sequence runs.
- rf_raddr  out  AW  to the register file read address.
- rf_waddr  out  AW  to the register file write address.
- rf_wdin  out  DW  to the register file write data.
- rf_wena  out  1  to the register file write enable.
- rf_rdout  in  DW  from the register file; combinational read data.

Behaviour:
- Reset (rst_n=0 at a clk edge) puts the block in these values:
  - state=CLEAR, clr_cnt=0, rr_ptr=0.
  - rvalid=0, rdata=0.
  - gnt=0 and busy=1 throughout the reset and the clear that follows.
- State machine has two states, CLEAR and ARB.
- CLEAR:
  - Each cycle drives rf_wena=1, rf_waddr=clr_cnt, rf_wdin=0, then increments clr_cnt.
  - Moves to ARB after the edge that writes address 63, so CLEAR lasts exactly 64 cycles.
  - gnt=0 for the whole state; requests wait.
- ARB with clr=0:
  - gnt[w]=1 for the winner w: the first i with req[i]=1, scanning from rr_ptr upward and wrapping modulo NREQ.
  - If no req is asserted, gnt=0.
  - After any grant, rr_ptr <= (w+1) mod NREQ. With no grant, rr_ptr holds.
- Granted write:
  - rf_wena=1, rf_waddr=req_addr[w], rf_wdin=req_wdata[w], all in the same cycle as the grant.
  - The data is committed at that clock edge.
- Granted read:
  - rf_raddr=req_addr[w] combinationally.
  - At the clock edge, rdata <= rf_rdout and rvalid <= onehot(w).
  - Latency is 1 cycle from the grant to rvalid.
  - rdata holds its value until the next granted read.
- rf_wena=0 in ARB when there is no write grant. rf_raddr and rf_waddr are don't-care when unused; drive them to 0.
- Write followed by read of the same address in consecutive cycles returns the new value, because the register file write lands at the edge.
- Only one transfer per cycle. A read and a write from different requesters in the same cycle are serialized by the arbiter.
- clr=1 in ARB:
  - gnt=0 in that cycle.
  - Next state is CLEAR with clr_cnt=0.
- clr=1 in CLEAR restarts clr_cnt at 0.
- A read granted in the cycle before clr still delivers its rvalid.
- rst_n=0 mid-CLEAR or mid-ARB aborts the operation. Any pending rvalid is dropped (rvalid=0) and CLEAR restarts.
- rst_n has priority over clr.
- Fairness: with all NREQ requesters continuously requesting, each is granted exactly once every NREQ cycles.

Optional Feature:
- Macro: REGFILE_ARB_R0_ZERO_EN.
- When defined, address 0 is hardwired to zero:
  - A granted write to address 0 is accepted (gnt asserted, rr_ptr advances), but rf_wena=0.
  - A granted read of address 0 returns rdata=0 regardless of rf_rdout.
  - CLEAR still writes address 0.
- When undefined, address 0 is an ordinary register.

Decomposition:
- Package regfile_pkg holds:
  - constants RF_AW=6, RF_DW=32, RF_DEPTH=64;
  - state enum arb_state_t {CLEAR, ARB}.
- Sub-module rr_arbiter (NREQ parameter):
  - inputs: req, ptr;
  - outputs: one-hot gnt and encoded winner index;
  - purely combinational.
- The top-level module holds the FSM, the clear counter, rr_ptr, and the read-response registers.

Test Plan:
- Reset release with req=4'b1111 held -> busy=1 and gnt=0 for 64 cycles, with rf_waddr stepping 0..63 and rf_wdin=0; on cycle 65, gnt=4'b0001.
- All requesters continuously reading -> gnt sequence 0001, 0010, 0100, 1000, 0001; each rvalid arrives one cycle after its gnt.
- Req0 writes 0xDEADBEEF to address 5 at cycle t; req2 reads address 5 at t+1 -> rvalid[2]=1 at t+2 with rdata=0xDEADBEEF.
- clr pulse in ARB while req1 is pending -> gnt=0 that cycle, busy=1 for 64 cycles; req1 is granted only after the clear completes, and a readback of address 5 gives 0.
- rst_n=0 at clear cycle 30 -> clr_cnt restarts at 0 and the full 64-cycle clear repeats; rvalid=0.
- With REGFILE_ARB_R0_ZERO_EN defined: write 0x12345678 to address 0 -> rf_wena=0; a later read of address 0 gives rdata=0. Without the macro, the same read gives rdata=0x12345678.
